// File: rtl/hex_entry_pkg.sv
// Shared definitions for the hex_entry pushbutton number editor.
// Holds the FSM encoding, key indices and the default debounce length.
package hex_entry_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDIT_MSB = 2'd1,
    EDIT_LSB = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 1000000;

  localparam int KEY_INC   = 0;
  localparam int KEY_DEC   = 1;
  localparam int KEY_SEL   = 2;
  localparam int KEY_ENTER = 3;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter, stable level and
// a single-cycle pulse on each accepted 0->1 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_50M,
  input  logic reset,
  input  logic key_raw,
  output logic press
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             stable;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
      press   <= 1'b0;
    end else begin
      // synchronizer stages
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // any sample matching the stable level restarts the interval
      if (sync_p1 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync_p1;
          cnt    <= '0;
          press  <= sync_p1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hex_entry.sv
// Four-button two-nibble hex editor: select a nibble, step it up/down,
// and commit the result as a one-cycle parallel-load strobe.
module hex_entry
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_sel,
  input  logic       key_enter,
  output logic [7:0] value,
  output logic       load,
  output logic [7:0] edit_value,
  output logic [1:0] digit_active,
  output logic       editing
);

  logic [3:0] keys_raw;
  logic [3:0] press;

  assign keys_raw = {key_enter, key_sel, key_dec, key_inc};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk_50M(clk_50M),
      .reset  (reset),
      .key_raw(keys_raw[i]),
      .press  (press[i])
    );
  end

  state_t     state;
  state_t     state_nxt;
  logic [7:0] work;
  logic [7:0] work_nxt;
  logic [7:0] value_nxt;

  // Nibbles wrap on their own; no carry or borrow leaves the nibble.
  function automatic logic [3:0] nib_step(input logic [3:0] nib, input logic up);
    return up ? nib + 4'd1 : nib - 4'd1;
  endfunction

  always_comb begin
    state_nxt    = state;
    work_nxt     = work;
    value_nxt    = value;
    load         = 1'b0;
    editing      = 1'b0;
    digit_active = 2'b00;
    case (state)
      IDLE: begin
        if (press[KEY_SEL]) begin
          state_nxt = EDIT_MSB;
          work_nxt  = value;
        end
      end
      EDIT_MSB, EDIT_LSB: begin
        editing      = 1'b1;
        digit_active = {state == EDIT_MSB, state == EDIT_LSB};
        // enter beats sel beats inc/dec; inc with dec cancels
        if (press[KEY_ENTER]) begin
          state_nxt = COMMIT;
          value_nxt = work;
        end else if (press[KEY_SEL]) begin
          state_nxt = (state == EDIT_MSB) ? EDIT_LSB : EDIT_MSB;
        end else if (press[KEY_INC] ^ press[KEY_DEC]) begin
          if (state == EDIT_MSB) work_nxt[7:4] = nib_step(work[7:4], press[KEY_INC]);
          else                   work_nxt[3:0] = nib_step(work[3:0], press[KEY_INC]);
        end
      end
      COMMIT: begin
        load      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state <= IDLE;
      work  <= 8'h00;
      value <= 8'h00;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      value <= value_nxt;
    end
  end

  assign edit_value = work;

endmodule

// File: doc/hex_entry.md
HEX_ENTRY -- requirements
Module: hex_entry

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clock cycles (20 ms at 50 MHz) needed to accept a key level change.
REQ-002 clk_50M  input  1  system clock; the single clock, all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 key_inc  input  1  raw pushbutton, active-high, asynchronous to clk_50M; increments the selected nibble.
REQ-005 key_dec  input  1  raw pushbutton, active-high, asynchronous; decrements the selected nibble.
REQ-006 key_sel  input  1  raw pushbutton, active-high, asynchronous; starts an edit or toggles the selected nibble.
REQ-007 key_enter  input  1  raw pushbutton, active-high, asynchronous; commits the edit.
REQ-008 value  output  8  last committed number, feeding the counter's parallel-load input.
REQ-009 load  output  1  one-cycle strobe, high in the cycle value updates.
REQ-010 edit_value  output  8  working number under edit, for the seven-segment display.
REQ-011 digit_active  output  2  one-hot selected nibble: [1]=MSB, [0]=LSB, 00 when not editing.
REQ-012 editing  output  1  high in EDIT_MSB or EDIT_LSB.

Function
REQ-013 Each key SHALL pass through a 2-flop synchronizer and then a debouncer.
REQ-014 Debouncer stable level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count from zero.
REQ-015 Debouncer SHALL emit a one-cycle press pulse on each stable 0->1 transition, DEBOUNCE_CYCLES+2 cycles after a clean raw rise; releases emit nothing; holding emits no repeats.
REQ-016 FSM states SHALL be IDLE, EDIT_MSB, EDIT_LSB, COMMIT.
REQ-017 IDLE: sel press -> EDIT_MSB and working register <= value; inc/dec/enter ignored.
REQ-018 EDIT_MSB: inc/dec modify working[7:4]; sel -> EDIT_LSB; enter -> COMMIT.
REQ-019 EDIT_LSB: inc/dec modify working[3:0]; sel -> EDIT_MSB; enter -> COMMIT.
REQ-020 Nibble arithmetic SHALL be modulo 16: F+1=0, 0-1=F, with no carry/borrow into the other nibble.
REQ-021 COMMIT SHALL last exactly one cycle: value <= working, load=1, then -> IDLE.
REQ-022 Same-cycle pulses SHALL be prioritized enter > sel > inc/dec, with only the winning action taken; inc and dec together with neither enter nor sel SHALL leave working unchanged.
REQ-023 load SHALL be high only in the COMMIT cycle, never for two consecutive cycles.
REQ-024 edit_value SHALL equal the working register in every state; in IDLE and COMMIT it equals value.

Reset
REQ-025 On reset: value=0x00, working=0x00, load=0, editing=0, digit_active=00, state=IDLE.
REQ-026 On reset: debouncer stable levels=0, debounce counters=0, synchronizer flops=0.
REQ-027 Reset mid-edit SHALL discard the working value without a load strobe.
REQ-028 A key held through reset release SHALL produce a press pulse only after the full debounce interval.

Structure
REQ-029 Shared package hex_entry_pkg SHALL hold the FSM state encoding and the default DEBOUNCE_CYCLES constant.
REQ-030 One sub-module key_debounce (synchronizer, counter, stable level, press pulse) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset -> value=0x00, load=0, editing=0, digit_active=00.
REQ-032 key_inc raw toggles 1/0 every cycle for 10 cycles, then held high -> exactly one inc pulse, 6 cycles after the final rise; in IDLE, edit_value stays 0x00.
REQ-033 sel, inc x3, sel, dec x1, enter -> edit_value=0x3F before enter; one-cycle load; value=0x3F; editing=0 next cycle.
REQ-034 From value=0xF0: sel, inc, enter -> value=0x00, not 0x100; from 0x00: sel, sel, dec, enter -> value=0x0F.
REQ-035 Edit 0x00 -> 0x50, then assert reset before enter -> no load, value=0x00, state IDLE.
REQ-036 In EDIT_MSB, enter and inc pulses in the same cycle -> commit with MSB unchanged; inc and dec together -> working unchanged.
